vga_pixel_pipe: RTL and testbench
=================================

VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

Interface
REQ-001 SHALL have port: clk  input  1  pixel clock (25.175 MHz domain, same as timing generator).
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: x, y  input  10 each  current pixel counters from timing generator.
REQ-004 SHALL have ports: hsync_in, vsync_in, blank_b_in  input  1 each  timing-generator outputs, aligned with x/y.
REQ-005 SHALL have ports: hsync, vsync, blank_b  output  1 each  sync/blank delayed to match pixel data.
REQ-006 SHALL have ports: r, g, b  output  4 each  pixel colour to DAC.
REQ-007 SHALL have write port: wr_valid in 1, wr_ready out 1, wr_x in 8, wr_y in 7, wr_color in 4 (palette index).
REQ-008 SHALL have palette port: pal_we in 1, pal_idx in 4, pal_rgb in 12 ({r,g,b}).
REQ-009 SHALL have clear port: clear_start in 1, clear_color in 4, busy out 1.

Function
REQ-010 SHALL hold a 160x120 framebuffer of 4-bit indices; each entry covers a 4x4 screen pixel block.
REQ-011 Read address SHALL be (y>>2)*160 + (x>>2), 15 bits, computed as shift-add (no multiplier); forced to 0 when blank_b_in low.
REQ-012 Pipeline: cycle N address presented; cycle N+1 RAM index registered; cycle N+2 palette RGB registered on r/g/b. Latency exactly 2 cycles.
REQ-013 hsync, vsync, blank_b SHALL be hsync_in/vsync_in/blank_b_in delayed by exactly 2 registers.
REQ-014 r/g/b SHALL be 0 whenever the delayed blank_b is 0.
REQ-015 Palette SHALL be 16x12-bit registers; pal_we writes pal_rgb to pal_idx at the clock edge; a pixel reading that entry in stage 2 on the following cycle sees the new value.
REQ-016 FSM states IDLE, CLEAR. IDLE->CLEAR on clear_start; CLEAR->IDLE after the write to address 19199.
REQ-017 In CLEAR, one framebuffer write per cycle, address counter 0..19199, data = clear_color captured at clear_start; busy=1; wr_ready=0; clear_start ignored.
REQ-018 In IDLE, wr_ready=1; a write SHALL be performed on cycles with wr_valid & wr_ready.
REQ-019 Writes with wr_x>=160 or wr_y>=120 SHALL be accepted (handshake completes) and discarded.
REQ-020 clear_start and wr_valid in the same IDLE cycle: the write completes that cycle; CLEAR begins the next cycle.
REQ-021 Read and write to the same address in one cycle: the read returns old data.
REQ-022 Display reads SHALL never stall; writes and clears do not affect read timing.

Reset
REQ-023 On reset_n low: state IDLE, clear counter 0, busy 0, wr_ready 0 while asserted, all pipeline registers 0 (r/g/b=0, blank_b=0), hsync=vsync=1.
REQ-024 Palette entry i SHALL reset to {i,i,i} (grey ramp).
REQ-025 Framebuffer contents are not reset; reset during CLEAR SHALL abort to IDLE leaving partially cleared contents.

Structure
REQ-026 Shared package vga_pkg SHALL hold HACTIVE/HFP/HSYN/HMAX, VACTIVE/VFP/VSYN/VMAX, FB_W=160, FB_H=120, FB_DEPTH=19200, SCALE_SHIFT=2, and the FSM state enum.
REQ-027 Framebuffer SHALL be sub-module fb_ram: simple dual-port, one write port, one synchronous-read port, 15-bit address, 4-bit data, inferable as EBR.

Verification
REQ-028 Reset, then x=0,y=0,blank_b_in=1 with fb[0]=0 -> two cycles later r/g/b=0,0,0, blank_b=1.
REQ-029 Write (wr_x=5,wr_y=3,color=7), pal_we idx7=12'hF80; drive x=20..23,y=12..15 -> r/g/b=F,8,0 exactly 2 cycles after each.
REQ-030 hsync_in pulse at cycle 100 -> hsync low at cycle 102; blank_b_in low -> r/g/b=0 regardless of fb.
REQ-031 clear_start with clear_color=3 -> busy high 19200 cycles, wr_ready low throughout; afterwards any visible pixel shows palette[3]=333.
REQ-032 Write wr_x=160,wr_y=0 -> wr_ready handshake completes, fb[0..19199] unchanged.
REQ-033 Assert reset_n low at clear count 5000 -> busy=0 immediately, IDLE after release, entries 0..4999 = clear_color.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, types and address helper for the VGA pixel pipeline.
package vga_pkg;

    // 640x480@60 timing, kept here so the timing generator and pipe agree.
    localparam int unsigned HACTIVE = 640;
    localparam int unsigned HFP     = 16;
    localparam int unsigned HSYN    = 96;
    localparam int unsigned HMAX    = 800;
    localparam int unsigned VACTIVE = 480;
    localparam int unsigned VFP     = 10;
    localparam int unsigned VSYN    = 2;
    localparam int unsigned VMAX    = 525;

    localparam int unsigned FB_W        = 160;
    localparam int unsigned FB_H        = 120;
    localparam int unsigned FB_DEPTH    = 19200;
    localparam int unsigned SCALE_SHIFT = 2;

    localparam int unsigned AW   = 15;
    localparam int unsigned CW   = 4;
    localparam int unsigned PAL_N = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_b;
    } sync_t;

    localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, blank_b: 1'b0};

    // row*160 + col as (row<<7)+(row<<5)+col, no multiplier
    function automatic logic [AW-1:0] fb_addr(input logic [7:0] row, input logic [7:0] col);
        return AW'({row, 7'b0}) + AW'({row, 5'b0}) + AW'(col);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// 160x120x4 framebuffer: one write port, one registered read port (read-before-write).
module fb_ram
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem_q [FB_DEPTH];
    logic [CW-1:0] rdata_q;

    // Contents are intentionally never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// Framebuffer-backed pixel pipeline: 2-cycle display read, palette lookup,
// host pixel writes and a full-screen clear engine.
module vga_pixel_pipe
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_b_in,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_b,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [3:0]  wr_color,
    input  logic        pal_we,
    input  logic [3:0]  pal_idx,
    input  logic [11:0] pal_rgb,
    input  logic        clear_start,
    input  logic [3:0]  clear_color,
    output logic        busy
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] clr_color_q, clr_color_d;
    logic          busy_q, busy_d;
    logic          wr_ready_q, wr_ready_d;

    rgb_t          pal_q [PAL_N];
    rgb_t          pal_d [PAL_N];
    sync_t         sync1_q, sync1_d;
    sync_t         sync2_q, sync2_d;
    rgb_t          rgb_q, rgb_d;

    logic          fb_we_c;
    logic [AW-1:0] fb_waddr_c;
    logic [CW-1:0] fb_wdata_c;
    logic [AW-1:0] fb_raddr_c;
    logic [CW-1:0] fb_rdata;
    logic          wr_fire_c;
    logic          wr_in_range_c;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_color_q <= clr_color_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_color_d = clr_color_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d     = CLEAR;
                    cnt_d       = '0;
                    clr_color_d = clear_color;
                end
            end
            CLEAR: begin
                if (cnt_q == AW'(FB_DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_fire_c     = wr_valid & wr_ready_q;
    assign wr_in_range_c = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

    // FSM outputs: framebuffer write port and next values of the status flags
    always_comb begin
        busy_d     = (state_d == CLEAR);
        wr_ready_d = (state_d == IDLE);
        fb_we_c    = 1'b0;
        fb_waddr_c = '0;
        fb_wdata_c = '0;
        if (state_q == CLEAR) begin
            fb_we_c    = 1'b1;
            fb_waddr_c = cnt_q;
            fb_wdata_c = clr_color_q;
        end else if (wr_fire_c && wr_in_range_c) begin
            fb_we_c    = 1'b1;
            fb_waddr_c = fb_addr(8'(wr_y), wr_x);
            fb_wdata_c = wr_color;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign fb_raddr_c = blank_b_in ? fb_addr(8'(y >> SCALE_SHIFT), 8'(x >> SCALE_SHIFT)) : '0;

    fb_ram u_fb_ram (
        .clk   (clk),
        .we    (fb_we_c),
        .waddr (fb_waddr_c),
        .wdata (fb_wdata_c),
        .raddr (fb_raddr_c),
        .rdata (fb_rdata)
    );

    // Palette update and display pipeline stages
    always_comb begin
        pal_d = pal_q;
        if (pal_we) begin
            pal_d[pal_idx] = rgb_t'(pal_rgb);
        end
        sync1_d = sync_t'{hsync: hsync_in, vsync: vsync_in, blank_b: blank_b_in};
        sync2_d = sync1_q;
        rgb_d   = sync1_q.blank_b ? pal_q[fb_rdata] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(PAL_N); i++) begin
                pal_q[i] <= rgb_t'{r: 4'(i), g: 4'(i), b: 4'(i)};
            end
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
            rgb_q   <= '0;
        end else begin
            pal_q   <= pal_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync    = sync2_q.hsync;
    assign vsync    = sync2_q.vsync;
    assign blank_b  = sync2_q.blank_b;
    assign r        = rgb_q.r;
    assign g        = rgb_q.g;
    assign b        = rgb_q.b;
    assign busy     = busy_q;
    assign wr_ready = wr_ready_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed self-checking bench for vga_pixel_pipe.
module tb_vga_pixel_pipe;

    logic        clk;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        hsync_in, vsync_in, blank_b_in;
    logic        hsync, vsync, blank_b;
    logic [3:0]  r, g, b;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [3:0]  wr_color;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_rgb;
    logic        clear_start;
    logic [3:0]  clear_color;
    logic        busy;

    int errors = 0;
    int checks = 0;

    vga_pixel_pipe dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .y           (y),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_b_in  (blank_b_in),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_b     (blank_b),
        .r           (r),
        .g           (g),
        .b           (b),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .pal_we      (pal_we),
        .pal_idx     (pal_idx),
        .pal_rgb     (pal_rgb),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wr_pix(input logic [7:0] px, input logic [6:0] py, input logic [3:0] c,
                          output logic rdy);
        wr_valid = 1'b1;
        wr_x     = px;
        wr_y     = py;
        wr_color = c;
        rdy      = wr_ready;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pal_wr(input logic [3:0] idx, input logic [11:0] rgb);
        pal_we  = 1'b1;
        pal_idx = idx;
        pal_rgb = rgb;
        @(negedge clk);
        pal_we  = 1'b0;
    endtask

    task automatic read_pix(input logic [9:0] px, input logic [9:0] py, output logic [11:0] rgb);
        x          = px;
        y          = py;
        blank_b_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rgb        = {r, g, b};
        blank_b_in = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync: got %b want 1", vsync); end
        checks++; if (blank_b !== 1'b0) begin errors++; $display("FAIL rst_blank: got %b want 0", blank_b); end
        checks++; if ({r, g, b} !== 12'h000) begin errors++; $display("FAIL rst_rgb: got %h want 000", {r, g, b}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b want 1", wr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_first_pixel;
        logic rdy;
        wr_pix(8'd0, 7'd0, 4'd0, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fp_wr_ready: got %b want 1", rdy); end
        x = 10'd0; y = 10'd0; blank_b_in = 1'b1;
        @(negedge clk);
        checks++; if (blank_b !== 1'b0) begin errors++; $display("FAIL fp_blank_1cyc: got %b want 0", blank_b); end
        @(negedge clk);
        checks++; if (blank_b !== 1'b1) begin errors++; $display("FAIL fp_blank_2cyc: got %b want 1", blank_b); end
        checks++; if ({r, g, b} !== 12'h000) begin errors++; $display("FAIL fp_rgb: got %h want 000", {r, g, b}); end
        blank_b_in = 1'b0;
    endtask

    task automatic test_clear;
        int n;
        int wr_hi;
        logic [11:0] rgb;
        logic [9:0] px [4];
        logic [9:0] py [4];
        px[0] = 10'd0;   py[0] = 10'd0;
        px[1] = 10'd4;   py[1] = 10'd0;
        px[2] = 10'd639; py[2] = 10'd479;
        px[3] = 10'd320; py[3] = 10'd240;
        // Write and clear requested in the same idle cycle
        clear_start = 1'b1; clear_color = 4'd3;
        wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd0; wr_color = 4'd2;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_start_ready: got %b want 1", wr_ready); end
        @(negedge clk);
        clear_start = 1'b0; wr_valid = 1'b0;
        n = 0; wr_hi = 0;
        while (busy === 1'b1 && n < 20000) begin
            if (wr_ready !== 1'b0) wr_hi++;
            if (n == 100) begin clear_start = 1'b1; clear_color = 4'd4; end
            if (n == 101) clear_start = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++; if (n != 19200) begin errors++; $display("FAIL clr_busy_len: got %0d want 19200", n); end
        checks++; if (wr_hi != 0) begin errors++; $display("FAIL clr_wr_ready_low: got %0d high cycles want 0", wr_hi); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_done_ready: got %b want 1", wr_ready); end
        for (int i = 0; i < 4; i++) begin
            read_pix(px[i], py[i], rgb);
            checks++;
            if (rgb !== 12'h333) begin
                errors++; $display("FAIL clr_pixel(%0d,%0d): got %h want 333", px[i], py[i], rgb);
            end
        end
    endtask

    task automatic test_oob;
        logic rdy;
        logic [11:0] rgb;
        wr_pix(8'd160, 7'd0, 4'd5, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL oob_x_ready: got %b want 1", rdy); end
        wr_pix(8'd0, 7'd120, 4'd5, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL oob_y_ready: got %b want 1", rdy); end
        wr_pix(8'd255, 7'd127, 4'd5, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL oob_xy_ready: got %b want 1", rdy); end
        read_pix(10'd0, 10'd4, rgb);
        checks++; if (rgb !== 12'h333) begin errors++; $display("FAIL oob_entry160: got %h want 333", rgb); end
        read_pix(10'd0, 10'd0, rgb);
        checks++; if (rgb !== 12'h333) begin errors++; $display("FAIL oob_entry0: got %h want 333", rgb); end
        read_pix(10'd636, 10'd476, rgb);
        checks++; if (rgb !== 12'h333) begin errors++; $display("FAIL oob_entry_last: got %h want 333", rgb); end
    endtask

    task automatic test_write_pixel;
        logic rdy;
        logic [11:0] rgb;
        wr_pix(8'd5, 7'd3, 4'd7, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wp_ready: got %b want 1", rdy); end
        pal_wr(4'd7, 12'hF80);
        // Stream the 4x4 block; each pixel appears two cycles after its coordinates
        for (int i = 0; i < 18; i++) begin
            if (i >= 2) begin
                checks++;
                if ({r, g, b} !== 12'hF80) begin
                    errors++; $display("FAIL wp_block_px%0d: got %h want f80", i - 2, {r, g, b});
                end
            end
            if (i < 16) begin
                x = 10'(20 + (i % 4)); y = 10'(12 + (i / 4)); blank_b_in = 1'b1;
            end else begin
                blank_b_in = 1'b0;
            end
            @(negedge clk);
        end
        read_pix(10'd24, 10'd12, rgb);
        checks++; if (rgb !== 12'h333) begin errors++; $display("FAIL wp_right_nbr: got %h want 333", rgb); end
        read_pix(10'd19, 10'd15, rgb);
        checks++; if (rgb !== 12'h333) begin errors++; $display("FAIL wp_left_nbr: got %h want 333", rgb); end
    endtask

    task automatic test_back_to_back;
        x = 10'd0; y = 10'd0; blank_b_in = 1'b1;
        wr_valid = 1'b1; wr_x = 8'd0; wr_y = 7'd0; wr_color = 4'd5;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        checks++; if ({r, g, b} !== 12'h333) begin errors++; $display("FAIL rw_same_old: got %h want 333", {r, g, b}); end
        @(negedge clk);
        checks++; if ({r, g, b} !== 12'h555) begin errors++; $display("FAIL rw_same_new: got %h want 555", {r, g, b}); end
        blank_b_in = 1'b0;
    endtask

    task automatic test_sync_blank;
        logic [11:0] rgb;
        hsync_in = 1'b0; vsync_in = 1'b0;
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL sync_d0: got %b want 1", hsync); end
        @(negedge clk);
        hsync_in = 1'b1; vsync_in = 1'b1;
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL sync_d1: got %b want 1", hsync); end
        @(negedge clk);
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_d2: got %b want 0", hsync); end
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_d2: got %b want 0", vsync); end
        @(negedge clk);
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_d3: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_d3: got %b want 1", vsync); end
        x = 10'd20; y = 10'd12; blank_b_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({r, g, b} !== 12'h000) begin errors++; $display("FAIL blank_rgb: got %h want 000", {r, g, b}); end
        checks++; if (blank_b !== 1'b0) begin errors++; $display("FAIL blank_out: got %b want 0", blank_b); end
        read_pix(10'd20, 10'd12, rgb);
        checks++; if (rgb !== 12'hF80) begin errors++; $display("FAIL unblank_rgb: got %h want f80", rgb); end
    endtask

    task automatic test_reset_during_clear;
        logic [11:0] rgb;
        clear_start = 1'b1; clear_color = 4'd9;
        @(negedge clk);
        clear_start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rdc_busy: got %b want 1", busy); end
        repeat (5000) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdc_busy_abort: got %b want 0", busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rdc_ready_rst: got %b want 0", wr_ready); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL rdc_hsync_rst: got %b want 1", hsync); end
        checks++; if (blank_b !== 1'b0) begin errors++; $display("FAIL rdc_blank_rst: got %b want 0", blank_b); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdc_idle_busy: got %b want 0", busy); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rdc_idle_ready: got %b want 1", wr_ready); end
        read_pix(10'd0, 10'd0, rgb);
        checks++; if (rgb !== 12'h999) begin errors++; $display("FAIL rdc_entry0: got %h want 999", rgb); end
        read_pix(10'd156, 10'd124, rgb);
        checks++; if (rgb !== 12'h999) begin errors++; $display("FAIL rdc_entry4999: got %h want 999", rgb); end
        read_pix(10'd160, 10'd124, rgb);
        checks++; if (rgb !== 12'h333) begin errors++; $display("FAIL rdc_entry5000: got %h want 333", rgb); end
        read_pix(10'd639, 10'd479, rgb);
        checks++; if (rgb !== 12'h333) begin errors++; $display("FAIL rdc_entry19199: got %h want 333", rgb); end
    endtask

    initial begin
        reset_n     = 1'b0;
        x           = '0;
        y           = '0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        blank_b_in  = 1'b0;
        wr_valid    = 1'b0;
        wr_x        = '0;
        wr_y        = '0;
        wr_color    = '0;
        pal_we      = 1'b0;
        pal_idx     = '0;
        pal_rgb     = '0;
        clear_start = 1'b0;
        clear_color = '0;

        test_reset();
        test_first_pixel();
        test_clear();
        test_oob();
        test_write_pixel();
        test_back_to_back();
        test_sync_blank();
        test_reset_during_clear();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
